pll_ctrl: RTL and testbench
===========================

PLL_CTRL -- requirements
Module: pll_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16, is the number of cycles pll_reset is held high per attempt.
REQ-002 Parameter LOCK_STABLE, default 256, is the number of consecutive synchronized lock-high cycles required before release.
REQ-003 Parameter LOCK_TIMEOUT, default 27000, is the cycle limit per attempt (1 ms at 27 MHz); it is 16 bits wide.
REQ-004 Parameter MAX_RETRY, default 3, is the number of timed-out attempts allowed before fail.
REQ-005 Parameters DEF_IDIV=6, DEF_FBDIV=11, DEF_ODIV=16 are the power-up divider selects, each 6 bits.
REQ-006 Port clk, input, 1 bit: the PLL reference clock (clkin net); the block runs only on this clock.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port cfg_valid, input, 1 bit: new divider request.
REQ-009 Port cfg_ready, output, 1 bit: a request is accepted when cfg_valid and cfg_ready are both high.
REQ-010 Ports cfg_idiv, cfg_fbdiv, cfg_odiv, input, 6 bits each: requested divider selects.
REQ-011 Ports pll_idsel, pll_fbdsel, pll_odsel, output, 6 bits each: registered divider selects driven to the rPLL IDSEL/FBDSEL/ODSEL pins.
REQ-012 Port pll_reset, output, 1 bit: drives rPLL RESET.
REQ-013 Port pll_lock, input, 1 bit: asynchronous rPLL LOCK.
REQ-014 Port sys_reset, output, 1 bit: active-high reset for logic clocked by clkout.
REQ-015 Ports ready and fail, output, 1 bit each: status flags.
REQ-016 Port retry_cnt, output, 3 bits: count of timed-out attempts since the last start.

Function
REQ-017 pll_lock SHALL pass through a 2-flop synchronizer, adding 2 cycles of latency; lock_s denotes its output.
REQ-018 States SHALL be PRST, WAIT_LOCK, STABLE, RUN and FAIL.
REQ-019 PRST: pll_reset=1 and sys_reset=1 for exactly RST_CYCLES cycles, then the state moves to WAIT_LOCK and the timeout counter clears.
REQ-020 WAIT_LOCK: when lock_s=1, the state moves to STABLE with the stable count set to 1.
REQ-021 STABLE: lock_s=0 returns the state to WAIT_LOCK and clears the stable count; when the count reaches LOCK_STABLE, the state moves to RUN.
REQ-022 The timeout counter SHALL run through WAIT_LOCK and STABLE without clearing on lock chatter; reaching LOCK_TIMEOUT increments retry_cnt (saturating at 7).
REQ-023 On timeout, if retry_cnt < MAX_RETRY after the increment, the state SHALL move to PRST; otherwise it moves to FAIL.
REQ-024 RUN: sys_reset=0 and ready=1, both registered so they change on the cycle the state becomes RUN.
REQ-025 RUN, lock_s=0: sys_reset=1 and ready=0 on the next cycle, retry_cnt clears, and the state moves to PRST.
REQ-026 FAIL: fail=1, pll_reset=1, sys_reset=1; the state stays in FAIL until a cfg accept or reset.
REQ-027 cfg_ready SHALL be 1 only in RUN or FAIL.
REQ-028 On accept: cfg values latch into the pll_*sel outputs on the next cycle, retry_cnt clears, fail=0, ready=0, sys_reset=1, and the state moves to PRST.
REQ-029 pll_*sel outputs SHALL change only on accept or reset, and are therefore stable whenever pll_reset=0.
REQ-030 A cfg accept and loss of lock in the same RUN cycle SHALL be handled as a cfg accept, with the new dividers latched.
REQ-031 When cfg_valid=1 in a non-accepting state, the request SHALL be neither latched nor lost; it waits for cfg_ready.

Reset
REQ-032 On reset: state=PRST, pll_reset=1, sys_reset=1, ready=0, fail=0, cfg_ready=0, retry_cnt=0, all counters 0, synchronizer flops 0, pll_*sel = DEF_* values.
REQ-033 Reset asserted mid-operation SHALL restore REQ-032 values on the next edge and discard any latched configuration.

Configuration
REQ-034 With macro PLL_CTRL_RETRY_EN defined, the block SHALL retry per REQ-023.
REQ-035 With PLL_CTRL_RETRY_EN undefined, the first timeout SHALL move to FAIL with retry_cnt=1, and MAX_RETRY is ignored.

Structure
REQ-036 Package pll_ctrl_pkg SHALL hold the state enum, the DEF_* divider constants and the counter width constants.
REQ-037 The synchronizer SHALL be a sub-module named pll_lock_sync.

Verification
Bench parameters: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=100, MAX_RETRY=2.
REQ-038 Power-up: release reset, raise pll_lock at cycle 10 -> pll_reset low after 4 cycles; sys_reset falls at cycle 20 (2 sync + 8 stable); pll_*sel = 6/11/16.
REQ-039 Chatter: drop lock for 1 cycle at stable count 5 -> count restarts; RUN is reached 8 cycles after the re-high is synchronized.
REQ-040 Timeout: lock never rises -> 2 PRST/WAIT cycles, then fail=1 and retry_cnt=2; without PLL_CTRL_RETRY_EN, fail=1 after the first 100 cycles with retry_cnt=1.
REQ-041 Reconfig: in RUN, present cfg 1/30/8 -> accept in 1 cycle, sys_reset=1, pll_*sel=1/30/8, pll_reset pulses for 4 cycles.
REQ-042 Loss of lock: drop lock in RUN -> sys_reset=1 within 3 cycles of the drop and PRST entered; simultaneous cfg accept -> new dividers latched.
REQ-043 Reset in STABLE -> all outputs return to REQ-032 values on the next cycle.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state type, divider defaults and counter widths for the rPLL controller.
package pll_ctrl_pkg;

   localparam int unsigned DivW     = 6;
   localparam int unsigned CntW     = 16;
   localparam int unsigned TimeoutW = 16;
   localparam int unsigned RetryW   = 3;

   // Power-up divider selects.
   localparam logic [DivW-1:0] DEF_IDIV_SEL  = 6'd6;
   localparam logic [DivW-1:0] DEF_FBDIV_SEL = 6'd11;
   localparam logic [DivW-1:0] DEF_ODIV_SEL  = 6'd16;

   typedef enum logic [2:0] {
      StPrst,
      StWaitLock,
      StStable,
      StRun,
      StFail
   } pll_state_e;

   typedef struct packed {
      logic [DivW-1:0] idiv;
      logic [DivW-1:0] fbdiv;
      logic [DivW-1:0] odiv;
   } pll_div_t;

   // Increment that holds at all-ones instead of wrapping.
   function automatic logic [RetryW-1:0] sat_inc(input logic [RetryW-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: two-flop synchronizer bringing the asynchronous rPLL LOCK into the clkin domain.
module pll_lock_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture; both stages clear on reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/pll_ctrl.sv
// pll_ctrl: rPLL bring-up sequencer. Pulses the PLL reset, waits for a stable lock (with a
// per-attempt timeout), releases sys_reset, and accepts divider reconfiguration in RUN/FAIL.
// Optional feature: define PLL_CTRL_RETRY_EN to retry timed-out attempts up to MAX_RETRY;
// without it the first timeout goes straight to FAIL.
module pll_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int unsigned          RST_CYCLES   = 16,
   parameter int unsigned          LOCK_STABLE  = 256,
   parameter logic [TimeoutW-1:0]  LOCK_TIMEOUT = 16'd27000,
   parameter int unsigned          MAX_RETRY    = 3,
   parameter logic [DivW-1:0]      DEF_IDIV     = DEF_IDIV_SEL,
   parameter logic [DivW-1:0]      DEF_FBDIV    = DEF_FBDIV_SEL,
   parameter logic [DivW-1:0]      DEF_ODIV     = DEF_ODIV_SEL
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [DivW-1:0]   cfg_idiv,
   input  logic [DivW-1:0]   cfg_fbdiv,
   input  logic [DivW-1:0]   cfg_odiv,
   output logic [DivW-1:0]   pll_idsel,
   output logic [DivW-1:0]   pll_fbdsel,
   output logic [DivW-1:0]   pll_odsel,
   output logic              pll_reset,
   input  logic              pll_lock,
   output logic              sys_reset,
   output logic              ready,
   output logic              fail,
   output logic [RetryW-1:0] retry_cnt
);

`ifdef PLL_CTRL_RETRY_EN
   localparam int unsigned RetryLimit = MAX_RETRY;
`else
   // Single attempt: any post-increment count of 1 or more selects FAIL; MAX_RETRY has no effect.
   localparam int unsigned RetryLimit = 1 + 0 * MAX_RETRY;
`endif

   pll_state_e          state_q, state_d;
   logic [CntW-1:0]     rst_cnt_q, rst_cnt_d;
   logic [CntW-1:0]     stab_cnt_q, stab_cnt_d;
   logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;
   logic [RetryW-1:0]   retry_q, retry_d, retry_inc;
   pll_div_t            div_q, div_d;
   logic                pll_reset_q, pll_reset_d;
   logic                sys_reset_q, sys_reset_d;
   logic                ready_q, ready_d;
   logic                fail_q, fail_d;
   logic                lock_s;
   logic                accept;

   pll_lock_sync u_lock_sync (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (pll_lock),
      .q_o   (lock_s)
   );

   assign cfg_ready = (state_q == StRun) || (state_q == StFail);
   assign accept    = cfg_valid & cfg_ready;
   assign retry_inc = sat_inc(retry_q);

   // Next-state, counter and divider logic; a cfg accept overrides every other transition.
   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      stab_cnt_d = stab_cnt_q;
      to_cnt_d   = to_cnt_q;
      retry_d    = retry_q;
      div_d      = div_q;

      unique case (state_q)
         StPrst: begin
            if (rst_cnt_q == CntW'(RST_CYCLES - 1)) begin
               state_d   = StWaitLock;
               rst_cnt_d = '0;
               to_cnt_d  = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + CntW'(1);
            end
         end
         StWaitLock, StStable: begin
            to_cnt_d = to_cnt_q + TimeoutW'(1);
            if (state_q == StWaitLock) begin
               if (lock_s) begin
                  state_d    = StStable;
                  stab_cnt_d = CntW'(1);
               end
            end else if (!lock_s) begin
               state_d    = StWaitLock;
               stab_cnt_d = '0;
            end else if (stab_cnt_q == CntW'(LOCK_STABLE)) begin
               state_d = StRun;
            end else begin
               stab_cnt_d = stab_cnt_q + CntW'(1);
            end
            // Timeout runs across lock chatter; a lock that just qualified still wins.
            if (state_d != StRun && to_cnt_q == LOCK_TIMEOUT - TimeoutW'(1)) begin
               retry_d    = retry_inc;
               stab_cnt_d = '0;
               to_cnt_d   = '0;
               rst_cnt_d  = '0;
               state_d    = (32'(retry_inc) < RetryLimit) ? StPrst : StFail;
            end
         end
         StRun: begin
            if (!lock_s) begin
               state_d    = StPrst;
               retry_d    = '0;
               rst_cnt_d  = '0;
               stab_cnt_d = '0;
            end
         end
         StFail: begin
         end
         default: begin
            state_d = StPrst;
         end
      endcase

      if (accept) begin
         state_d    = StPrst;
         div_d      = '{idiv: cfg_idiv, fbdiv: cfg_fbdiv, odiv: cfg_odiv};
         retry_d    = '0;
         rst_cnt_d  = '0;
         stab_cnt_d = '0;
         to_cnt_d   = '0;
      end
   end

   // Status outputs decoded from the next state so they register on the transition edge.
   always_comb begin
      pll_reset_d = (state_d == StPrst) || (state_d == StFail);
      sys_reset_d = (state_d != StRun);
      ready_d     = (state_d == StRun);
      fail_d      = (state_d == StFail);
   end

   // State, counters, dividers and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StPrst;
         rst_cnt_q   <= '0;
         stab_cnt_q  <= '0;
         to_cnt_q    <= '0;
         retry_q     <= '0;
         div_q       <= '{idiv: DEF_IDIV, fbdiv: DEF_FBDIV, odiv: DEF_ODIV};
         pll_reset_q <= 1'b1;
         sys_reset_q <= 1'b1;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         stab_cnt_q  <= stab_cnt_d;
         to_cnt_q    <= to_cnt_d;
         retry_q     <= retry_d;
         div_q       <= div_d;
         pll_reset_q <= pll_reset_d;
         sys_reset_q <= sys_reset_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

   assign pll_idsel  = div_q.idiv;
   assign pll_fbdsel = div_q.fbdiv;
   assign pll_odsel  = div_q.odiv;
   assign pll_reset  = pll_reset_q;
   assign sys_reset  = sys_reset_q;
   assign ready      = ready_q;
   assign fail       = fail_q;
   assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl: directed bench for pll_ctrl (RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=100,
// MAX_RETRY=2). Edge E0 is the last edge with reset high; checks sample 1 time unit after an edge.
module tb_pll_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [5:0] cfg_idiv, cfg_fbdiv, cfg_odiv;
   logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
   logic       pll_reset;
   logic       pll_lock;
   logic       sys_reset;
   logic       ready;
   logic       fail;
   logic [2:0] retry_cnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int          cyc      = 0;

`ifdef PLL_CTRL_RETRY_EN
   localparam int FailEdge  = 208;
   localparam int RetryFail = 2;
   localparam int RetryMid  = 1;
`else
   localparam int FailEdge  = 104;
   localparam int RetryFail = 1;
   localparam int RetryMid  = 0;
`endif

   always #5 clk = ~clk;

   pll_ctrl #(
      .RST_CYCLES   (4),
      .LOCK_STABLE  (8),
      .LOCK_TIMEOUT (16'd100),
      .MAX_RETRY    (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_idiv   (cfg_idiv),
      .cfg_fbdiv  (cfg_fbdiv),
      .cfg_odiv   (cfg_odiv),
      .pll_idsel  (pll_idsel),
      .pll_fbdsel (pll_fbdsel),
      .pll_odsel  (pll_odsel),
      .pll_reset  (pll_reset),
      .pll_lock   (pll_lock),
      .sys_reset  (sys_reset),
      .ready      (ready),
      .fail       (fail),
      .retry_cnt  (retry_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (E%0d)", tag, got, exp, cyc);
      end
   endtask

   // Advance to #1 after edge k.
   task automatic step_to(input int k);
      while (cyc < k) begin
         @(posedge clk);
         cyc++;
      end
      #1;
   endtask

   task automatic apply_reset();
      reset     = 1'b1;
      pll_lock  = 1'b0;
      cfg_valid = 1'b0;
      cfg_idiv  = '0;
      cfg_fbdiv = '0;
      cfg_odiv  = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc   = 0;
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
      check_eq({tag, "_sys_reset"}, 32'(sys_reset), 32'd1);
      check_eq({tag, "_ready"},     32'(ready),     32'd0);
      check_eq({tag, "_fail"},      32'(fail),      32'd0);
      check_eq({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
      check_eq({tag, "_retry"},     32'(retry_cnt), 32'd0);
      check_eq({tag, "_sel"}, 32'({pll_idsel, pll_fbdsel, pll_odsel}),
               32'({6'd6, 6'd11, 6'd16}));
   endtask

   // Lock raised so it is first sampled at E10; RUN is entered at E20.
   task automatic bring_up();
      apply_reset();
      step_to(9);
      pll_lock = 1'b1;
      step_to(20);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at E%0d", cyc);
      $fatal(1);
   end

   initial begin
      // Power-up sequence.
      apply_reset();
      check_reset_state("rst");
      step_to(3);
      check_eq("pu_prst_held", 32'(pll_reset), 32'd1);
      step_to(4);
      check_eq("pu_prst_rel", 32'(pll_reset), 32'd0);
      check_eq("pu_sys_wait", 32'(sys_reset), 32'd1);
      step_to(9);
      pll_lock = 1'b1;
      step_to(19);
      check_eq("pu_sys_pre", 32'(sys_reset), 32'd1);
      check_eq("pu_ready_pre", 32'(ready), 32'd0);
      step_to(20);
      check_eq("pu_sys_run", 32'(sys_reset), 32'd0);
      check_eq("pu_ready_run", 32'(ready), 32'd1);
      check_eq("pu_cfg_ready", 32'(cfg_ready), 32'd1);
      check_eq("pu_sel", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({6'd6, 6'd11, 6'd16}));

      // Loss of lock in RUN: low sampled at E22, seen by the FSM at E24.
      step_to(21);
      pll_lock = 1'b0;
      step_to(23);
      check_eq("lol_sys_still", 32'(sys_reset), 32'd0);
      step_to(24);
      check_eq("lol_sys", 32'(sys_reset), 32'd1);
      check_eq("lol_ready", 32'(ready), 32'd0);
      check_eq("lol_pll_reset", 32'(pll_reset), 32'd1);
      check_eq("lol_cfg_ready", 32'(cfg_ready), 32'd0);

      // Chatter: lock low for one sample at E15, stable count restarts.
      apply_reset();
      step_to(9);
      pll_lock = 1'b1;
      step_to(14);
      pll_lock = 1'b0;
      step_to(15);
      pll_lock = 1'b1;
      step_to(20);
      check_eq("chat_no_run", 32'(ready), 32'd0);
      step_to(25);
      check_eq("chat_sys_pre", 32'(sys_reset), 32'd1);
      step_to(26);
      check_eq("chat_sys_run", 32'(sys_reset), 32'd0);
      check_eq("chat_ready", 32'(ready), 32'd1);

      // Reconfig in RUN, then reset while in STABLE.
      bring_up();
      step_to(21);
      cfg_valid = 1'b1;
      cfg_idiv  = 6'd1;
      cfg_fbdiv = 6'd30;
      cfg_odiv  = 6'd8;
      step_to(22);
      cfg_valid = 1'b0;
      check_eq("rc_sel", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({6'd1, 6'd30, 6'd8}));
      check_eq("rc_sys", 32'(sys_reset), 32'd1);
      check_eq("rc_ready", 32'(ready), 32'd0);
      check_eq("rc_pll_reset_on", 32'(pll_reset), 32'd1);
      check_eq("rc_cfg_ready", 32'(cfg_ready), 32'd0);
      step_to(25);
      check_eq("rc_pll_reset_held", 32'(pll_reset), 32'd1);
      step_to(26);
      check_eq("rc_pll_reset_off", 32'(pll_reset), 32'd0);
      step_to(28);
      reset = 1'b1;
      step_to(29);
      check_reset_state("rst_stable");
      reset = 1'b0;

      // Loss of lock and cfg accept in the same RUN cycle (E24).
      bring_up();
      step_to(21);
      pll_lock = 1'b0;
      step_to(23);
      cfg_valid = 1'b1;
      cfg_idiv  = 6'd3;
      cfg_fbdiv = 6'd40;
      cfg_odiv  = 6'd2;
      step_to(24);
      cfg_valid = 1'b0;
      check_eq("sim_sel", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({6'd3, 6'd40, 6'd2}));
      check_eq("sim_sys", 32'(sys_reset), 32'd1);
      check_eq("sim_pll_reset", 32'(pll_reset), 32'd1);

      // Timeout with a request pending from WAIT_LOCK until FAIL accepts it.
      apply_reset();
      step_to(50);
      cfg_valid = 1'b1;
      cfg_idiv  = 6'd2;
      cfg_fbdiv = 6'd20;
      cfg_odiv  = 6'd4;
      step_to(51);
      check_eq("to_pend_sel", 32'({pll_idsel, pll_fbdsel, pll_odsel}),
               32'({6'd6, 6'd11, 6'd16}));
      step_to(FailEdge - 1);
      check_eq("to_fail_pre", 32'(fail), 32'd0);
      check_eq("to_retry_pre", 32'(retry_cnt), 32'(RetryMid));
      step_to(FailEdge);
      check_eq("to_fail", 32'(fail), 32'd1);
      check_eq("to_retry", 32'(retry_cnt), 32'(RetryFail));
      check_eq("to_pll_reset", 32'(pll_reset), 32'd1);
      check_eq("to_sys", 32'(sys_reset), 32'd1);
      check_eq("to_cfg_ready", 32'(cfg_ready), 32'd1);
      check_eq("to_sel_held", 32'({pll_idsel, pll_fbdsel, pll_odsel}),
               32'({6'd6, 6'd11, 6'd16}));
      step_to(FailEdge + 1);
      cfg_valid = 1'b0;
      check_eq("fa_sel", 32'({pll_idsel, pll_fbdsel, pll_odsel}), 32'({6'd2, 6'd20, 6'd4}));
      check_eq("fa_fail", 32'(fail), 32'd0);
      check_eq("fa_retry", 32'(retry_cnt), 32'd0);
      check_eq("fa_cfg_ready", 32'(cfg_ready), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
